stack_op_sequencer: RTL and testbench
=====================================

Name: stack_op_sequencer

Overview:
- Decode stage for Thumb-style 16-bit stack instructions, directly upstream of the stack controller.
- Classifies each fetched halfword into the controller's one-hot stack opcode and extracts the register list, destination fields and scaled immediate.
- Generates the controller's state-write enable.
- Holds the opcode for the full multi-cycle PUSH/POP walk and stalls fetch meanwhile.

Parameters:
- SEQ_LEN, 11, cycles a PUSH/POP occupies the controller: 1 header + 9 list positions + 1 tail.
- CNT_W, 4, width of the sequence counter; must satisfy 2^CNT_W >= SEQ_LEN.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- instr_valid  in  1  fetch presents a valid halfword on instr_in.
- instr_in  in  16  fetched instruction halfword.
- stall  out  1  fetch must hold instr_in/instr_valid; combinational from state.
- op_sel  out  8  one-hot opcode to controller: NOP 0x00, PUSH 0x01, POP 0x02, ADDSP 0x04, SUBSP 0x08, MOVSP 0x10, ADDS 0x20, LDRSP 0x40, STRSP 0x80.
- ST_Wen  out  1  controller SP/position register update enable.
- RL  out  9  register list; bit8 = LR (PUSH) or PC (POP), bits7:0 = R7..R0.
- Rd0  out  3  instr[2:0], MOVSP destination.
- Rd1  out  3  instr[10:8], ADDS/LDRSP/STRSP destination or source.
- imm_off  out  16  zero-extended byte offset for the SP ALU.
- busy  out  1  PUSH/POP sequence in progress.

Behaviour:
- Reset: state IDLE, counter 0; op_sel, RL, Rd0, Rd1, imm_off cleared; ST_Wen 0, stall 0, busy 0.
- Reset mid-sequence aborts immediately, with no completion cycle.
- Accept rule: an instruction is accepted on a rising edge where instr_valid=1 and stall=0. All outputs are registered, so a decode appears the cycle after acceptance (latency 1).
- Decode on instr_in:
  - [15:9]=1011010 -> PUSH.
  - [15:9]=1011110 -> POP.
  - For both: RL={instr[8], instr[7:0]}.
  - [15:7]=101100000 -> ADDSP, imm_off=imm7<<2.
  - [15:7]=101100001 -> SUBSP, imm_off=imm7<<2.
  - [15:3]=0100011001101 -> MOVSP.
  - [15:11]=10101 -> ADDS, imm_off=imm8<<2.
  - [15:11]=10011 -> LDRSP, imm_off=imm8<<2.
  - [15:11]=10010 -> STRSP, imm_off=imm8<<2.
  - Anything else -> NOP.
- Field hygiene: RL is 0 for all non-PUSH/POP opcodes; imm_off is 0 for PUSH, POP, MOVSP and NOP.
- ST_Wen=1 exactly when op_sel != NOP. ST_Wen must be 0 on NOP because the controller loads SP from its data input whenever the opcode is unrecognised.
- FSM:
  - IDLE: outputs NOP/ST_Wen=0.
    - Accepting PUSH or POP -> MULTI, counter=0.
    - Accepting any other stack op -> SINGLE.
    - Accepting a non-stack instruction stays IDLE.
  - SINGLE: decoded opcode for exactly one cycle, ST_Wen=1, stall=0.
    - A new accept in this cycle goes to SINGLE, MULTI or IDLE per its decode, so single ops issue back-to-back.
    - No accept -> IDLE, outputs NOP.
  - MULTI: op_sel and RL held constant, ST_Wen=1 every cycle, busy=1.
    - Counter increments each cycle.
    - stall=1 while counter < SEQ_LEN-1.
    - On the cycle counter==SEQ_LEN-1: stall=0, so the next instruction can be accepted at that edge and issue in the cycle right after the tail; otherwise -> IDLE.
    - Total: exactly SEQ_LEN cycles with ST_Wen=1 and SEQ_LEN-1 stall cycles.
- Empty register list (RL=0): still runs the full SEQ_LEN cycles; the controller walks all positions regardless.
- instr_in changes while stall=1 are ignored; decoded fields stay latched.
- Counter never wraps within a sequence; it is cleared on every MULTI entry.

Optional Feature:
- Macro STK_PERF_CNT_EN.
- Defined: adds output port stall_cnt (16 bits), a saturating count (holds at 0xFFFF) of cycles with stall=1. Cleared by reset.
- Undefined: port and counter absent; all other behaviour identical.

Test Plan:
- Reset: hold reset 2 cycles with instr_valid=1, instr_in=0xB505 -> op_sel=0x00, ST_Wen=0, stall=0, RL=0, imm_off=0 throughout; no sequence starts.
- PUSH {R0,R2,LR}: instr_in=0xB505 accepted -> next cycle op_sel=0x01, RL=0x105; op_sel held 11 cycles with ST_Wen=1; stall=1 for first 10; busy falls after cycle 11.
- POP {R1,PC} with queued SUB SP,#8: 0xBD02 then 0xB082 held valid -> RL=0x102 for 11 cycles; at cycle 12 op_sel=0x08, imm_off=0x0008, RL=0, for one cycle; then NOP.
- Back-to-back singles: 0x9B04 then 0x9101 on consecutive cycles -> op_sel 0x40 (Rd1=3, imm_off=16) then 0x80 (Rd1=1, imm_off=4); stall never asserted.
- Reset mid-sequence: accept 0xB505, assert reset in sequence cycle 5 -> next cycle op_sel=0, ST_Wen=0, stall=0, busy=0; new 0x466D then decodes to op_sel=0x10, Rd0=5.
- Non-stack instruction: 0x1840 -> op_sel=0x00, ST_Wen=0; with STK_PERF_CNT_EN defined, stall_cnt reads 10 after one full PUSH.

Source files
------------

// File: rtl/stack_op_sequencer.sv
// rtl/stack_op_sequencer.sv - Thumb stack-instruction decode and PUSH/POP sequencer (option: STK_PERF_CNT_EN adds stall_cnt)
module stack_op_sequencer #(
    parameter int SEQ_LEN = 11,
    parameter int CNT_W   = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              instr_valid,
    input  logic [15:0]       instr_in,
    output logic              stall,
    output logic [7:0]        op_sel,
    output logic              ST_Wen,
    output logic [8:0]        RL,
    output logic [2:0]        Rd0,
    output logic [2:0]        Rd1,
    output logic [15:0]       imm_off,
`ifdef STK_PERF_CNT_EN
    output logic [15:0]       stall_cnt,
`endif
    output logic              busy
);

    localparam logic [7:0] OP_NOP   = 8'h00;
    localparam logic [7:0] OP_PUSH  = 8'h01;
    localparam logic [7:0] OP_POP   = 8'h02;
    localparam logic [7:0] OP_ADDSP = 8'h04;
    localparam logic [7:0] OP_SUBSP = 8'h08;
    localparam logic [7:0] OP_MOVSP = 8'h10;
    localparam logic [7:0] OP_ADDS  = 8'h20;
    localparam logic [7:0] OP_LDRSP = 8'h40;
    localparam logic [7:0] OP_STRSP = 8'h80;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SEQ_LEN - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SINGLE = 2'd1,
        MULTI  = 2'd2
    } state_t;

    state_t           state;
    state_t           next_state;
    logic [CNT_W-1:0] cnt;
    logic             accept;

    logic [7:0]  dec_op;
    logic [8:0]  dec_rl;
    logic [15:0] dec_imm;
    logic        dec_multi;

    always_comb begin
        dec_op  = OP_NOP;
        dec_rl  = '0;
        dec_imm = '0;
        if (instr_in[15:9] == 7'b1011010) begin
            dec_op = OP_PUSH;
            dec_rl = instr_in[8:0];
        end else if (instr_in[15:9] == 7'b1011110) begin
            dec_op = OP_POP;
            dec_rl = instr_in[8:0];
        end else if (instr_in[15:7] == 9'b101100000) begin
            dec_op  = OP_ADDSP;
            dec_imm = {7'd0, instr_in[6:0], 2'b00};
        end else if (instr_in[15:7] == 9'b101100001) begin
            dec_op  = OP_SUBSP;
            dec_imm = {7'd0, instr_in[6:0], 2'b00};
        end else if (instr_in[15:3] == 13'b0100011001101) begin
            dec_op = OP_MOVSP;
        end else if (instr_in[15:11] == 5'b10101) begin
            dec_op  = OP_ADDS;
            dec_imm = {6'd0, instr_in[7:0], 2'b00};
        end else if (instr_in[15:11] == 5'b10011) begin
            dec_op  = OP_LDRSP;
            dec_imm = {6'd0, instr_in[7:0], 2'b00};
        end else if (instr_in[15:11] == 5'b10010) begin
            dec_op  = OP_STRSP;
            dec_imm = {6'd0, instr_in[7:0], 2'b00};
        end
    end

    assign dec_multi = (dec_op == OP_PUSH) || (dec_op == OP_POP);
    assign accept    = instr_valid && !stall;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= next_state;
            if (accept || next_state != MULTI) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    always_comb begin
        next_state = IDLE;
        if (state == MULTI && stall) begin
            next_state = MULTI;
        end else if (accept) begin
            if (dec_multi) begin
                next_state = MULTI;
            end else if (dec_op != OP_NOP) begin
                next_state = SINGLE;
            end
        end
    end

    always_comb begin
        busy   = (state == MULTI);
        stall  = (state == MULTI) && (cnt < CNT_LAST);
        ST_Wen = (op_sel != OP_NOP);
    end

    // Fields latch on accept, hold through a PUSH/POP walk, and fall back to NOP otherwise.
    always_ff @(posedge clk) begin
        if (reset) begin
            op_sel  <= OP_NOP;
            RL      <= '0;
            Rd0     <= '0;
            Rd1     <= '0;
            imm_off <= '0;
        end else if (accept) begin
            op_sel  <= dec_op;
            RL      <= dec_rl;
            Rd0     <= (dec_op == OP_NOP) ? 3'd0 : instr_in[2:0];
            Rd1     <= (dec_op == OP_NOP) ? 3'd0 : instr_in[10:8];
            imm_off <= dec_imm;
        end else if (next_state != MULTI) begin
            op_sel  <= OP_NOP;
            RL      <= '0;
            Rd0     <= '0;
            Rd1     <= '0;
            imm_off <= '0;
        end
    end

`ifdef STK_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt <= '0;
        end else if (stall && stall_cnt != 16'hFFFF) begin
            stall_cnt <= stall_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_stack_op_sequencer.sv
// tb/tb_stack_op_sequencer.sv - randomized and directed bench against a transaction-level model
module tb_stack_op_sequencer;

    localparam int SEQ_LEN = 11;

    logic        clk = 1'b0;
    logic        reset;
    logic        instr_valid;
    logic [15:0] instr_in;
    logic        stall;
    logic [7:0]  op_sel;
    logic        ST_Wen;
    logic [8:0]  RL;
    logic [2:0]  Rd0;
    logic [2:0]  Rd1;
    logic [15:0] imm_off;
    logic        busy;
`ifdef STK_PERF_CNT_EN
    logic [15:0] stall_cnt;
`endif

    int n_checks = 0;
    int n_errors = 0;

    stack_op_sequencer #(.SEQ_LEN(SEQ_LEN), .CNT_W(4)) dut (
        .clk(clk),
        .reset(reset),
        .instr_valid(instr_valid),
        .instr_in(instr_in),
        .stall(stall),
        .op_sel(op_sel),
        .ST_Wen(ST_Wen),
        .RL(RL),
        .Rd0(Rd0),
        .Rd1(Rd1),
        .imm_off(imm_off),
`ifdef STK_PERF_CNT_EN
        .stall_cnt(stall_cnt),
`endif
        .busy(busy)
    );

    always #5 clk = ~clk;

    // Reference state: the instruction currently issued and how many more cycles it owns.
    logic [7:0]  m_op;
    logic [8:0]  m_rl;
    logic [15:0] m_imm;
    logic [2:0]  m_rd0, m_rd1;
    int          m_left;
    logic        m_busy;
    int          m_stall_cnt;

    logic [15:0] cls_mask  [9] = '{16'hFE00, 16'hFE00, 16'hFF80, 16'hFF80, 16'hFFF8,
                                   16'hF800, 16'hF800, 16'hF800, 16'h0000};
    logic [15:0] cls_match [9] = '{16'hB400, 16'hBC00, 16'hB000, 16'hB080, 16'h4668,
                                   16'hA800, 16'h9800, 16'h9000, 16'h0000};
    logic [7:0]  cls_op    [9] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                                   8'h20, 8'h40, 8'h80, 8'h00};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [7:0] ref_op(input logic [15:0] ins);
        for (int k = 0; k < 8; k++) begin
            if ((ins & cls_mask[k]) == cls_match[k]) return cls_op[k];
        end
        return 8'h00;
    endfunction

    function automatic logic [15:0] ref_imm(input logic [15:0] ins, input logic [7:0] op);
        if (op == 8'h04 || op == 8'h08) return 16'(int'(ins % 128) * 4);
        if (op == 8'h20 || op == 8'h40 || op == 8'h80) return 16'(int'(ins % 256) * 4);
        return 16'h0000;
    endfunction

    function automatic logic m_stall();
        return m_busy && (m_left > 0);
    endfunction

    task automatic model_clear();
        m_op = 8'h00; m_rl = 9'h0; m_imm = 16'h0; m_rd0 = 3'd0; m_rd1 = 3'd0;
        m_left = 0; m_busy = 1'b0;
    endtask

    task automatic compare_all();
        check("op_sel", 32'(op_sel), 32'(m_op));
        check("ST_Wen", 32'(ST_Wen), 32'(m_op != 8'h00));
        check("RL", 32'(RL), 32'(m_rl));
        check("imm_off", 32'(imm_off), 32'(m_imm));
        check("busy", 32'(busy), 32'(m_busy));
        check("stall", 32'(stall), 32'(m_stall()));
        if (m_op == 8'h10) check("Rd0", 32'(Rd0), 32'(m_rd0));
        if (m_op == 8'h20 || m_op == 8'h40 || m_op == 8'h80) check("Rd1", 32'(Rd1), 32'(m_rd1));
`ifdef STK_PERF_CNT_EN
        check("stall_cnt", 32'(stall_cnt), 32'(m_stall_cnt));
`endif
    endtask

    // One clock: compare at the falling edge, drive, then advance the model on the rising edge.
    task automatic cycle(input logic rst, input logic v, input logic [15:0] ins);
        logic acc;
        logic [7:0] op;
        @(negedge clk);
        compare_all();
        reset = rst;
        instr_valid = v;
        instr_in = ins;
        acc = v && !m_stall();
        @(posedge clk);
        if (rst) begin
            model_clear();
            m_stall_cnt = 0;
        end else begin
            if (m_stall() && m_stall_cnt < 65535) m_stall_cnt++;
            if (acc) begin
                op     = ref_op(ins);
                m_op   = op;
                m_rl   = (op == 8'h01 || op == 8'h02) ? ins[8:0] : 9'h0;
                m_imm  = ref_imm(ins, op);
                m_rd0  = ins[2:0];
                m_rd1  = ins[10:8];
                m_busy = (op == 8'h01 || op == 8'h02);
                m_left = m_busy ? SEQ_LEN - 1 : 0;
            end else if (m_left > 0) begin
                m_left--;
            end else begin
                model_clear();
            end
        end
    endtask

    function automatic logic [15:0] rand_instr();
        int k;
        k = $urandom_range(0, 9);
        if (k > 8) k = 8;
        return cls_match[k] | (16'($urandom) & ~cls_mask[k]);
    endfunction

    initial begin
        reset = 1'b1;
        instr_valid = 1'b0;
        instr_in = 16'h0000;
        model_clear();
        m_stall_cnt = 0;

        // Reset held with a PUSH presented must not start anything.
        cycle(1'b1, 1'b1, 16'hB505);
        cycle(1'b1, 1'b1, 16'hB505);
        #1;
        check("rst_op", 32'(op_sel), 32'h0);
        check("rst_stall", 32'(stall), 32'h0);

        // PUSH {R0,R2,LR}
        cycle(1'b0, 1'b1, 16'hB505);
        #1;
        check("push_op", 32'(op_sel), 32'h01);
        check("push_rl", 32'(RL), 32'h105);
        for (int i = 0; i < SEQ_LEN; i++) cycle(1'b0, 1'b0, 16'h0000);
        #1;
        check("push_done_busy", 32'(busy), 32'h0);
`ifdef STK_PERF_CNT_EN
        check("push_stall_cnt", 32'(stall_cnt), 32'd10);
`endif

        // POP {R1,PC} with SUB SP,#8 queued behind it
        cycle(1'b0, 1'b1, 16'hBD02);
        for (int i = 0; i < SEQ_LEN; i++) cycle(1'b0, 1'b1, 16'hB082);
        #1;
        check("pop_sub_op", 32'(op_sel), 32'h08);
        check("pop_sub_imm", 32'(imm_off), 32'h0008);
        check("pop_sub_rl", 32'(RL), 32'h0);
        cycle(1'b0, 1'b0, 16'h0000);
        #1;
        check("pop_sub_nop", 32'(op_sel), 32'h00);

        // Back-to-back single-cycle ops
        cycle(1'b0, 1'b1, 16'h9B04);
        #1;
        check("ldr_op", 32'(op_sel), 32'h40);
        check("ldr_rd1", 32'(Rd1), 32'd3);
        cycle(1'b0, 1'b1, 16'h9101);
        #1;
        check("str_op", 32'(op_sel), 32'h80);
        check("str_imm", 32'(imm_off), 32'd4);
        check("str_stall", 32'(stall), 32'h0);

        // Reset in sequence cycle 5
        cycle(1'b0, 1'b1, 16'hB505);
        for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, 16'h0000);
        cycle(1'b1, 1'b0, 16'h0000);
        #1;
        check("midrst_op", 32'(op_sel), 32'h0);
        check("midrst_busy", 32'(busy), 32'h0);
        cycle(1'b0, 1'b1, 16'h466D);
        #1;
        check("movsp_op", 32'(op_sel), 32'h10);
        check("movsp_rd0", 32'(Rd0), 32'd5);

        // Non-stack instruction
        cycle(1'b0, 1'b1, 16'h1840);
        #1;
        check("nonstack_op", 32'(op_sel), 32'h00);
        check("nonstack_wen", 32'(ST_Wen), 32'h0);

        for (int i = 0; i < 3000; i++) begin
            cycle($urandom_range(0, 99) == 0, $urandom_range(0, 3) != 0, rand_instr());
        end
        cycle(1'b0, 1'b0, 16'h0000);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
